dmem_responder: RTL and testbench

//  Memory-side responder for data-memory traffic: accepts byte-lane word requests
//  (byte address + 4-bit lane strobe) over a valid/ready handshake and returns

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_responder_if.sv | 33 +++
 rtl/dmem_bank.sv | 34 +++
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Defines the FSM state type, lane count and the strobe/alignment legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int LANES = 4;

  // A strobe is legal only if it is a byte, an aligned half or the full word,
  // and the low address bits point at its lowest enabled lane.
  function automatic logic be_legal(
    input logic [3:0] be,
    input logic [1:0] addr_lo
  );
    logic ok;
    ok = 1'b0;
    case (be)
      4'b0001: ok = (addr_lo == 2'd0);
      4'b0010: ok = (addr_lo == 2'd1);
      4'b0100: ok = (addr_lo == 2'd2);
      4'b1000: ok = (addr_lo == 2'd3);
      4'b0011: ok = (addr_lo == 2'd0);
      4'b1100: ok = (addr_lo == 2'd2);
      4'b1111: ok = (addr_lo == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/completion bundle between load/store unit and data-memory responder.
// master = requester side, slave = responder side.
interface dmem_responder_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [3:0]            req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bank.sv
// Word-organised data RAM built from four byte-lane arrays.
// Ports: clk, addr_i (word index), we_i (per-lane write), wdata_i, re_i, rdata_o (registered).
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [2**AW];
    logic [7:0] rd_q;

    // Read register only loads on re_i, so it also serves as the
    // holding register for the pending completion.
    always_ff @(posedge clk) begin
      if (we_i[l]) begin
        mem[addr_i] <= wdata_i[8*l +: 8];
      end
      if (re_i) begin
        rd_q <= mem[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding byte-lane request, RD_LAT-cycle completion.
// Ports: clk, rst (sync, active-high), bus (slave side of dmem_responder_if).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1
) (
  input logic          clk,
  input logic          rst,
  dmem_responder_if.slave bus
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  dmem_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        err_q, err_d;

  logic              accept;
  logic              ready;
  logic              valid;
  logic              legal;
  logic [3:0]        bank_we;
  logic              bank_re;
  logic [DATA_W-1:0] bank_rdata;

  assign legal = be_legal(bus.req_be, bus.req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    accept  = 1'b0;
    ready   = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          rd_d    = ~bus.req_we & legal;
          err_d   = ~legal;
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == 3'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Writes commit on the accept edge; rejected requests never touch RAM.
  assign bank_we = {LANES{accept & bus.req_we & legal}} & bus.req_be;
  assign bank_re = accept & ~bus.req_we & legal;

  dmem_bank #(
    .AW(DM_ADDRESS - 2)
  ) u_bank (
    .clk     (clk),
    .addr_i  (bus.req_addr[DM_ADDRESS-1:2]),
    .we_i    (bank_we),
    .wdata_i (bus.req_wdata),
    .re_i    (bank_re),
    .rdata_o (bank_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid;
  assign bus.rsp_err   = valid & err_q;
  assign bus.rsp_rdata = (valid & rd_q) ? bank_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (RD_LAT 1 and 3) against a word-array model.
// Directed steps first, then randomized traffic.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [31:0] mdl [2][128];

  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();
  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus3 ();

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic v, input logic we,
                         input logic [8:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    if (sel) begin
      bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = a;
      bus3.req_be = be; bus3.req_wdata = wd;
    end else begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a;
      bus1.req_be = be; bus1.req_wdata = wd;
    end
  endtask

  task automatic set_rr(input bit sel, input logic r);
    if (sel) bus3.rsp_ready = r;
    else bus1.rsp_ready = r;
  endtask

  function automatic logic o_rv(input bit sel);
    return sel ? bus3.rsp_valid : bus1.rsp_valid;
  endfunction
  function automatic logic o_qr(input bit sel);
    return sel ? bus3.req_ready : bus1.req_ready;
  endfunction
  function automatic logic [31:0] o_rd(input bit sel);
    return sel ? bus3.rsp_rdata : bus1.rsp_rdata;
  endfunction
  function automatic logic o_er(input bit sel);
    return sel ? bus3.rsp_err : bus1.rsp_err;
  endfunction

  // Legal strobe shapes, with the lowest lane deciding the required offset.
  function automatic bit m_legal(input logic [3:0] be, input logic [8:0] a);
    int low;
    if (!(be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF})) return 0;
    low = -1;
    for (int i = 3; i >= 0; i--) if (be[i]) low = i;
    return int'(a[1:0]) == low;
  endfunction

  // One full transaction: latency, hold stability and handshake are checked here.
  task automatic xact(input bit sel, input logic we, input logic [8:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd,
                      output logic er);
    int lat;
    int exp_lat;
    exp_lat = sel ? 3 : 1;
    @(negedge clk);
    set_req(sel, 1'b1, we, a, be, wd);
    set_rr(sel, hold == 0);
    chk("req_ready_idle", 32'(o_qr(sel)), 32'd1);
    @(posedge clk);
    #1;
    set_req(sel, 1'b0, we, a, be, wd);
    lat = 1;
    while (!o_rv(sel) && lat < 20) begin
      chk("req_ready_wait", 32'(o_qr(sel)), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = o_rd(sel);
    er = o_er(sel);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(o_rv(sel)), 32'd1);
      chk("hold_rdata", o_rd(sel), rd);
      chk("hold_err", 32'(o_er(sel)), 32'(er));
      chk("hold_req_ready", 32'(o_qr(sel)), 32'd0);
    end
    set_rr(sel, 1'b1);
    @(posedge clk);
    #1;
    chk("post_valid", 32'(o_rv(sel)), 32'd0);
    chk("post_req_ready", 32'(o_qr(sel)), 32'd1);
    set_rr(sel, 1'b0);
  endtask

  // Transaction checked against the model; model updated for legal writes.
  task automatic op(input bit sel, input logic we, input logic [8:0] a,
                    input logic [3:0] be, input logic [31:0] wd,
                    input int hold);
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    bit          ok;
    int          sidx;
    sidx = sel ? 1 : 0;
    ok = m_legal(be, a);
    xact(sel, we, a, be, wd, hold, rd, er);
    chk("err", 32'(er), 32'(!ok));
    chk("rdata", rd, (!we && ok) ? mdl[sidx][a[8:2]] : 32'h0);
    if (we && ok) begin
      w = mdl[sidx][a[8:2]];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      mdl[sidx][a[8:2]] = w;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [8:0]  a;
    logic [3:0]  be;
    logic [3:0]  lbe [7];
    n_pass  = 0;
    n_total = 0;
    lbe = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus1.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus1.rsp_err), 32'd0);
    chk("rst3_req_ready", 32'(bus3.req_ready), 32'd1);
    chk("rst3_rsp_valid", 32'(bus3.rsp_valid), 32'd0);

    // 2: word write then read
    op(0, 1'b1, 9'h010, 4'hF, 32'hDEADBEEF, 0);
    xact(0, 1'b0, 9'h010, 4'hF, 32'h0, 0, rd, er);
    chk("sw_lw_rdata", rd, 32'hDEADBEEF);
    chk("sw_lw_err", 32'(er), 32'd0);

    // 3: byte and half stores merge into the word
    op(0, 1'b1, 9'h013, 4'h8, 32'h55000000, 0);
    xact(0, 1'b0, 9'h010, 4'hF, 32'h0, 0, rd, er);
    chk("sb_rdata", rd, 32'h55ADBEEF);
    op(0, 1'b1, 9'h012, 4'hC, 32'h12340000, 1);
    xact(0, 1'b0, 9'h010, 4'hF, 32'h0, 0, rd, er);
    chk("sh_rdata", rd, 32'h1234BEEF);

    // 4: rejected requests
    xact(0, 1'b1, 9'h011, 4'h3, 32'hFFFFFFFF, 0, rd, er);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'h0);
    xact(0, 1'b1, 9'h010, 4'h5, 32'hFFFFFFFF, 0, rd, er);
    chk("bad_be_err", 32'(er), 32'd1);
    xact(0, 1'b0, 9'h010, 4'h0, 32'h0, 0, rd, er);
    chk("zero_be_err", 32'(er), 32'd1);
    chk("zero_be_rdata", rd, 32'h0);
    xact(0, 1'b0, 9'h010, 4'hF, 32'h0, 0, rd, er);
    chk("err_no_write", rd, 32'h1234BEEF);

    // 5: RD_LAT=3 with a stalled requester
    op(1, 1'b1, 9'h020, 4'hF, 32'hA5A51234, 0);
    xact(1, 1'b0, 9'h020, 4'hF, 32'h0, 4, rd, er);
    chk("lat3_rdata", rd, 32'hA5A51234);

    // 6: reset in WAIT after a write accept
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 9'h040, 4'hF, 32'hCAFEF00D);
    set_rr(1, 1'b1);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl[1][16] = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("midrst_valid", 32'(bus3.rsp_valid), 32'd0);
      chk("midrst_ready", 32'(bus3.req_ready), 32'd1);
      @(negedge clk);
    end
    set_rr(1, 1'b0);
    xact(1, 1'b0, 9'h040, 4'hF, 32'h0, 0, rd, er);
    chk("midrst_data", rd, 32'hCAFEF00D);

    // Fill both RAMs so every later read has a defined model value
    for (int w = 0; w < 128; w++) begin
      op(0, 1'b1, 9'(w * 4), 4'hF, $urandom, 0);
      op(1, 1'b1, 9'(w * 4), 4'hF, $urandom, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      a  = 9'($urandom_range(0, 511));
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        be = lbe[$urandom_range(0, 6)];
        for (int i = 3; i >= 0; i--) if (be[i]) a[1:0] = 2'(i);
      end
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, be,
         $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
